sccb_slave_regs: RTL
====================

Name: sccb_slave_regs

Overview:
- SCCB responder: the camera-side end of the SCCB link that our master drives.
- Decodes 3-phase writes and 2-phase (sub-address) plus 2-phase (read) transactions from an oversampled sclk/sdat pair.
- Drives ack and read-data bits, and exposes a simple register-file port.
- Used as a camera model in simulation, and in-fabric to emulate OV7670 register space for board-level SCCB loopback tests.

Parameters:
- SLV_ID, 7'h21, 7-bit device ID answered (8-bit write address 0x42, read address 0x43).
- SYNC_STAGES, 2, synchroniser depth for the sclk and sdat inputs (≥2).

Ports:
- clk  in  1  FPGA clock; must be ≥16× sclk frequency.
- rst_n  in  1  Reset: synchronous, active-low.
- sclk  in  1  SCCB clock from master (asynchronous).
- sdat_in  in  1  SCCB data as seen on the bus (asynchronous).
- sdat_on  out  1  1 = slave drives sdat_out onto the bus.
- sdat_out  out  1  Bit value driven while sdat_on=1.
- reg_we  out  1  1-cycle write strobe.
- reg_addr  out  8  Current sub-address; valid with reg_we and rd_req.
- reg_wdata  out  8  Write data; valid with reg_we.
- rd_req  out  1  1-cycle read request for reg_addr.
- reg_rdata  in  8  Read data; sampled exactly 1 clk after rd_req.
- busy  out  1  1 from START detect to STOP detect.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, reg_addr=0, FSM=IDLE, synchronisers cleared. Reset mid-transaction releases the bus (sdat_on=0) on the same edge; the rest of that transaction is ignored until the next START.
- Input path: SYNC_STAGES flops on sclk and sdat, plus one history flop each. sclk_rise, sclk_fall, START (sdat 1→0 while sclk=1) and STOP (sdat 0→1 while sclk=1) are single-cycle events. Pin-to-event latency is SYNC_STAGES+1 clk.
- Bits are sampled on sclk_rise, MSB first. A 4-bit counter runs 0..8; count 8 is the 9th (ack / don't-care) bit.
- The slave changes sdat_on/sdat_out only on sclk_fall, or on STOP/reset/START.
- FSM states: IDLE, ID_RX, ID_ACK, ADDR_RX, ADDR_ACK, DATA_RX, DATA_ACK, RD_TX, RD_NA, IGNORE.
  - START from any state → ID_RX, bit count cleared, sdat_on=0, busy=1.
  - STOP from any state → IDLE, sdat_on=0, busy=0.
  - ID_RX: after 8 bits, compare bits[7:1] with SLV_ID.
    - Match and RW=0 → ID_ACK, write mode.
    - Match and RW=1 → ID_ACK, read mode, rd_req pulses on the same cycle.
    - Mismatch → IGNORE.
  - *_ACK states: on the sclk_fall after the 8th bit, sdat_on=1 and sdat_out=0. On the next sclk_fall, release (sdat_on=0), then go to the next state: ADDR_RX, DATA_RX, RD_TX or IGNORE.
  - ADDR_RX: after 8 bits, load reg_addr (sub-address). If STOP arrives now, the sub-address persists for later reads and no reg_we is issued.
  - DATA_RX: after 8 bits, reg_wdata = byte and reg_we pulses 1 clk; then DATA_ACK → IGNORE. There is no auto-increment; extra bytes get no ack.
  - Read mode: the shift register is loaded from reg_rdata 1 clk after rd_req. RD_TX: on each sclk_fall, sdat_on=1 and sdat_out = next bit MSB-first, 8 bits in total. On the sclk_fall after bit 8, release and enter RD_NA. The master's NA bit is sampled and ignored; then IGNORE.
  - IGNORE: sdat_on=0; wait for STOP or START.
- Repeated START mid-byte: the partial byte is discarded, with no reg_we.
- sclk edge coincident with START/STOP: START/STOP wins.
- reg_addr holds its value between transactions. reg_wdata holds until the next write.

Decomposition:
- Shared package sccb_pkg holds:
  - FSM state encoding.
  - SCCB_ID_OV7670 = 7'h21.
  - Bit-count width and ack-bit index (8).
  - The package is also usable by the master bench.
- One natural sub-module, sccb_line_sync: synchronisers plus sclk_rise/sclk_fall/START/STOP event detection.

Test Plan:
- Write: START, 0x42, 0x12, 0x80, STOP.
  - sdat_on=1/sdat_out=0 during all three 9th bits.
  - Exactly one reg_we, with reg_addr=0x12 and reg_wdata=0x80.
  - busy falls after STOP.
- Read:
  - START, 0x42, 0x0A, STOP sets reg_addr=0x0A with no reg_we.
  - Then START, 0x43, with the stub returning 0x76 one clk after rd_req.
  - Slave shifts out 0,1,1,1,0,1,1,0 on successive sclk_fall; bus released after 8 bits.
- Wrong ID: START, 0x60, 0x12, 0x80, STOP → sdat_on never 1; no reg_we; no rd_req.
- Repeated START after 4 data bits of 0x42/0x12/..., followed by a full write 0x42/0x34/0x55 → single reg_we (0x34, 0x55).
- Extra byte: 0x42/0x20/0x11/0x22/STOP → one reg_we (0x20, 0x11); no ack on 4th byte.
- rst_n=0 held one clk while the slave drives ack → sdat_on=0 on that edge; subsequent bytes ignored until a new START; the next full write works normally.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: definitions shared by the SCCB responder and any SCCB master bench.
//   - SCCB_ID_OV7670 : 7-bit device ID of the OV7670 camera (write 0x42 / read 0x43)
//   - CNT_W          : width of the per-byte bit counter
//   - ACK_BIT_IDX    : counter value of the 9th (ack / don't-care) bit
//   - sccb_state_e   : responder FSM state encoding
package sccb_pkg;

  localparam logic [6:0] SCCB_ID_OV7670 = 7'h21;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] ACK_BIT_IDX = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID_RX,
    S_ID_ACK,
    S_ADDR_RX,
    S_ADDR_ACK,
    S_DATA_RX,
    S_DATA_ACK,
    S_RD_TX,
    S_RD_NA,
    S_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_slave_regs_if.sv
// sccb_slave_regs_if: SCCB line and register-file port of the SCCB responder.
//   sclk, sdat_in         : bus clock and bus data level (asynchronous to clk)
//   sdat_on, sdat_out     : responder drives sdat_out onto the bus while sdat_on=1
//   reg_we/reg_wdata      : single-cycle write strobe with its data
//   rd_req                : single-cycle read request for reg_addr
//   reg_addr              : current sub-address, valid with reg_we and rd_req
//   reg_rdata             : read data, captured exactly one clk after rd_req
//   busy                  : high from START detect to STOP detect
// Strobe semantics: reg_we and rd_req carry no back-pressure; each is high for
// exactly one clk per event, and the register file must accept it on that edge.
interface sccb_slave_regs_if;
  logic       sclk;
  logic       sdat_in;
  logic       sdat_on;
  logic       sdat_out;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       rd_req;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sclk, sdat_in, reg_rdata,
    output sdat_on, sdat_out, reg_we, reg_addr, reg_wdata, rd_req, busy
  );

  modport master (
    output sclk, sdat_in, reg_rdata,
    input  sdat_on, sdat_out, reg_we, reg_addr, reg_wdata, rd_req, busy
  );
endinterface

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronises sclk/sdat into the clk domain and produces
// single-cycle line events.
//   clk, rst_n     : system clock, synchronous active-low reset
//   i_sclk, i_sdat : raw asynchronous bus pins
//   o_sclk_rise    : sclk 0->1
//   o_sclk_fall    : sclk 1->0
//   o_start        : sdat 1->0 while sclk held high
//   o_stop         : sdat 0->1 while sclk held high
//   o_sdat         : synchronised sdat level aligned with the events
// Events are registered, so pin-to-event latency is SYNC_STAGES+1 clk.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sclk,
  input  logic i_sdat,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sdat
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_hist;
  logic                   r_sdat_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_start;
  logic                   r_stop;
  logic                   w_sclk;
  logic                   w_sdat;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdat = r_sdat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_sdat_hist <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_sdat};
      r_sclk_hist <= w_sclk;
      r_sdat_hist <= w_sdat;
      r_rise      <= w_sclk & ~r_sclk_hist;
      r_fall      <= ~w_sclk & r_sclk_hist;
      // sclk must be high on both sides of the sdat edge, so a START/STOP can
      // never be confused with data changing around an sclk edge.
      r_start     <= w_sclk & r_sclk_hist & r_sdat_hist & ~w_sdat;
      r_stop      <= w_sclk & r_sclk_hist & ~r_sdat_hist & w_sdat;
    end
  end

  assign o_sclk_rise = r_rise;
  assign o_sclk_fall = r_fall;
  assign o_start     = r_start;
  assign o_stop      = r_stop;
  // The history flop holds the level the registered events were computed from.
  assign o_sdat      = r_sdat_hist;

endmodule

// File: rtl/sccb_slave_regs.sv
// sccb_slave_regs: SCCB responder with a simple register-file port.
//   clk, rst_n  : system clock (>=16x sclk), synchronous active-low reset
//   if_bus      : SCCB line + register port (see sccb_slave_regs_if)
//   o_dbg_state : current FSM state, for observation only
// Handles 3-phase writes (ID, sub-address, data) and 2-phase reads (ID, data).
// Bits are sampled on sclk rise MSB first; the bus is only changed on sclk
// fall, START, STOP or reset.
module sccb_slave_regs
  import sccb_pkg::*;
#(
  parameter logic [6:0] SLV_ID      = SCCB_ID_OV7670,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sccb_slave_regs_if.slave   if_bus,
  output sccb_state_e        o_dbg_state
);

  logic w_rise, w_fall, w_start, w_stop, w_sdat;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sclk      (if_bus.sclk),
    .i_sdat      (if_bus.sdat_in),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall),
    .o_start     (w_start),
    .o_stop      (w_stop),
    .o_sdat      (w_sdat)
  );

  sccb_state_e      r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [7:0]       r_shift, w_nxt_shift;
  logic             r_rd_mode, w_nxt_rd_mode;
  logic             r_sdat_on, w_nxt_sdat_on;
  logic             r_sdat_out, w_nxt_sdat_out;
  logic             r_reg_we, w_nxt_reg_we;
  logic             r_rd_req, w_nxt_rd_req;
  logic [7:0]       r_reg_addr, w_nxt_reg_addr;
  logic [7:0]       r_reg_wdata, w_nxt_reg_wdata;
  logic             r_busy, w_nxt_busy;
  logic [7:0]       w_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rd_mode   <= 1'b0;
      r_sdat_on   <= 1'b0;
      r_sdat_out  <= 1'b0;
      r_reg_we    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_shift     <= w_nxt_shift;
      r_rd_mode   <= w_nxt_rd_mode;
      r_sdat_on   <= w_nxt_sdat_on;
      r_sdat_out  <= w_nxt_sdat_out;
      r_reg_we    <= w_nxt_reg_we;
      r_rd_req    <= w_nxt_rd_req;
      r_reg_addr  <= w_nxt_reg_addr;
      r_reg_wdata <= w_nxt_reg_wdata;
      r_busy      <= w_nxt_busy;
    end
  end

  // Byte as it stands once the bit sampled on this rise is shifted in.
  assign w_byte = {r_shift[6:0], w_sdat};

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_shift     = r_shift;
    w_nxt_rd_mode   = r_rd_mode;
    w_nxt_sdat_on   = r_sdat_on;
    w_nxt_sdat_out  = r_sdat_out;
    w_nxt_reg_we    = 1'b0;
    w_nxt_rd_req    = 1'b0;
    w_nxt_reg_addr  = r_reg_addr;
    w_nxt_reg_wdata = r_reg_wdata;
    w_nxt_busy      = r_busy;

    // Register file answers one clk after the request; sclk edges are far
    // apart, so this never collides with a shift.
    if (r_rd_req) w_nxt_shift = if_bus.reg_rdata;

    if (w_stop) begin
      w_nxt_state    = S_IDLE;
      w_nxt_cnt      = '0;
      w_nxt_sdat_on  = 1'b0;
      w_nxt_sdat_out = 1'b0;
      w_nxt_busy     = 1'b0;
    end else if (w_start) begin
      // Also covers a repeated START: any partial byte is simply dropped.
      w_nxt_state    = S_ID_RX;
      w_nxt_cnt      = '0;
      w_nxt_sdat_on  = 1'b0;
      w_nxt_sdat_out = 1'b0;
      w_nxt_busy     = 1'b1;
    end else begin
      case (r_state)
        S_ID_RX, S_ADDR_RX, S_DATA_RX: begin
          if (w_rise) begin
            w_nxt_shift = w_byte;
            w_nxt_cnt   = r_cnt + 4'd1;
            if (r_cnt == ACK_BIT_IDX - 4'd1) begin
              if (r_state == S_ID_RX) begin
                if (w_byte[7:1] == SLV_ID) begin
                  w_nxt_state   = S_ID_ACK;
                  w_nxt_rd_mode = w_byte[0];
                  w_nxt_rd_req  = w_byte[0];
                end else begin
                  w_nxt_state = S_IGNORE;
                end
              end else if (r_state == S_ADDR_RX) begin
                w_nxt_reg_addr = w_byte;
                w_nxt_state    = S_ADDR_ACK;
              end else begin
                w_nxt_reg_wdata = w_byte;
                w_nxt_reg_we    = 1'b1;
                w_nxt_state     = S_DATA_ACK;
              end
            end
          end
        end

        S_ID_ACK, S_ADDR_ACK, S_DATA_ACK: begin
          if (w_fall) begin
            if (!r_sdat_on) begin
              // First fall after the 8th bit: pull the line low for the ack.
              w_nxt_sdat_on  = 1'b1;
              w_nxt_sdat_out = 1'b0;
            end else begin
              w_nxt_sdat_on  = 1'b0;
              w_nxt_sdat_out = 1'b0;
              w_nxt_cnt      = '0;
              if (r_state == S_ID_ACK) begin
                if (r_rd_mode) begin
                  // The fall ending the ack is also where read bit 7 goes out.
                  w_nxt_state    = S_RD_TX;
                  w_nxt_sdat_on  = 1'b1;
                  w_nxt_sdat_out = r_shift[7];
                  w_nxt_shift    = {r_shift[6:0], 1'b0};
                  w_nxt_cnt      = 4'd1;
                end else begin
                  w_nxt_state = S_ADDR_RX;
                end
              end else if (r_state == S_ADDR_ACK) begin
                w_nxt_state = S_DATA_RX;
              end else begin
                w_nxt_state = S_IGNORE;
              end
            end
          end
        end

        S_RD_TX: begin
          if (w_fall) begin
            if (r_cnt == ACK_BIT_IDX) begin
              w_nxt_sdat_on  = 1'b0;
              w_nxt_sdat_out = 1'b0;
              w_nxt_cnt      = '0;
              w_nxt_state    = S_RD_NA;
            end else begin
              w_nxt_sdat_on  = 1'b1;
              w_nxt_sdat_out = r_shift[7];
              w_nxt_shift    = {r_shift[6:0], 1'b0};
              w_nxt_cnt      = r_cnt + 4'd1;
            end
          end
        end

        // The master's NA bit carries no information for us.
        S_RD_NA: begin
          if (w_rise) w_nxt_state = S_IGNORE;
        end

        default: begin
          w_nxt_sdat_on = 1'b0;
        end
      endcase
    end
  end

  assign if_bus.sdat_on   = r_sdat_on;
  assign if_bus.sdat_out  = r_sdat_out;
  assign if_bus.reg_we    = r_reg_we;
  assign if_bus.reg_addr  = r_reg_addr;
  assign if_bus.reg_wdata = r_reg_wdata;
  assign if_bus.rd_req    = r_rd_req;
  assign if_bus.busy      = r_busy;
  assign o_dbg_state      = r_state;

endmodule
